// File: rtl/exc_sequencer_if.sv
// Bundle between the decoder/CP0 side and the trap/ERET sequencer.
// The master drives decoded requests and CP0 state; the slave (sequencer) drives CP0 controls.
interface exc_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             ena;
  logic             is_syscall;
  logic             is_break;
  logic             is_teq;
  logic             teq_equal;
  logic             is_eret;
  logic [31:0]      npc;
  logic [31:0]      status_in;
  logic [31:0]      exc_addr_in;
  logic             exception;
  logic             eret;
  logic [4:0]       cause;
  logic [31:0]      npc_out;
  logic             pc_redirect;
  logic [31:0]      redirect_addr;
  logic             stall;
  logic             exc_masked;
  logic [CNT_W-1:0] exc_count;

  modport master (
    output ena, is_syscall, is_break, is_teq, teq_equal, is_eret, npc, status_in, exc_addr_in,
    input  exception, eret, cause, npc_out, pc_redirect, redirect_addr, stall, exc_masked, exc_count
  );

  modport slave (
    input  ena, is_syscall, is_break, is_teq, teq_equal, is_eret, npc, status_in, exc_addr_in,
    output exception, eret, cause, npc_out, pc_redirect, redirect_addr, stall, exc_masked, exc_count
  );
endinterface

// File: rtl/exc_sequencer.sv
// Trap/ERET sequencer feeding CP0: one-cycle exception/eret pulse, then a one-cycle PC redirect,
// plus a saturating count of taken traps.
module exc_sequencer #(
  parameter logic [31:0] EXC_VECTOR = 32'h00400004,
  parameter int          CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  exc_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SIG_EXC  = 2'd1,
    SIG_ERET = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
  localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
  localparam logic [4:0] CAUSE_TEQ     = 5'b01101;

  state_t           state, state_next;
  logic             exception_q, exception_d;
  logic             eret_q, eret_d;
  logic             pc_redirect_q, pc_redirect_d;
  logic             exc_masked_q, exc_masked_d;
  logic [4:0]       cause_q, cause_d;
  logic [31:0]      npc_q, npc_d;
  logic [31:0]      redirect_q, redirect_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             trap;
  logic             trap_enabled;
  logic [4:0]       trap_cause;
  logic             unused_status;

  assign trap          = bus.is_syscall | bus.is_break | (bus.is_teq & bus.teq_equal);
  assign unused_status = ^bus.status_in[31:4];

  // Highest-priority trap picks both the cause code and its Status enable bit.
  always_comb begin
    trap_cause   = CAUSE_TEQ;
    trap_enabled = bus.status_in[3];
    if (bus.is_syscall) begin
      trap_cause   = CAUSE_SYSCALL;
      trap_enabled = bus.status_in[1];
    end else if (bus.is_break) begin
      trap_cause   = CAUSE_BREAK;
      trap_enabled = bus.status_in[2];
    end
  end

  always_comb begin
    state_next    = state;
    exception_d   = 1'b0;
    eret_d        = 1'b0;
    pc_redirect_d = 1'b0;
    exc_masked_d  = 1'b0;
    cause_d       = cause_q;
    npc_d         = npc_q;
    redirect_d    = redirect_q;
    count_d       = count_q;
    case (state)
      IDLE: begin
        if (trap) begin
          if (bus.status_in[0] & trap_enabled) begin
            state_next  = SIG_EXC;
            exception_d = 1'b1;
            cause_d     = trap_cause;
            npc_d       = bus.npc;
          end else begin
            exc_masked_d = 1'b1;
          end
        end else if (bus.is_eret) begin
          state_next = SIG_ERET;
          eret_d     = 1'b1;
        end
      end
      SIG_EXC: begin
        state_next    = REDIRECT;
        pc_redirect_d = 1'b1;
        redirect_d    = EXC_VECTOR;
        count_d       = (&count_q) ? count_q : count_q + 1'b1;
      end
      // CP0 has restored EPC onto exc_addr_in by the negedge inside this state.
      SIG_ERET: begin
        state_next    = REDIRECT;
        pc_redirect_d = 1'b1;
        redirect_d    = bus.exc_addr_in;
      end
      REDIRECT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      exception_q   <= 1'b0;
      eret_q        <= 1'b0;
      pc_redirect_q <= 1'b0;
      exc_masked_q  <= 1'b0;
      cause_q       <= 5'd0;
      npc_q         <= 32'd0;
      redirect_q    <= 32'd0;
      count_q       <= '0;
    end else if (bus.ena) begin
      state         <= state_next;
      exception_q   <= exception_d;
      eret_q        <= eret_d;
      pc_redirect_q <= pc_redirect_d;
      exc_masked_q  <= exc_masked_d;
      cause_q       <= cause_d;
      npc_q         <= npc_d;
      redirect_q    <= redirect_d;
      count_q       <= count_d;
    end
  end

  assign bus.exception     = exception_q;
  assign bus.eret          = eret_q;
  assign bus.pc_redirect   = pc_redirect_q;
  assign bus.exc_masked    = exc_masked_q;
  assign bus.cause         = cause_q;
  assign bus.npc_out       = npc_q;
  assign bus.redirect_addr = redirect_q;
  assign bus.exc_count     = count_q;
  assign bus.stall         = (state != IDLE);

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed self-checking bench for exc_sequencer: default instance plus a CNT_W=2 instance
// used for counter saturation.
module tb_exc_sequencer;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  int   exp_cnt [5];

  exc_sequencer_if #(.CNT_W(8)) bus  ();
  exc_sequencer_if #(.CNT_W(2)) bus2 ();

  exc_sequencer #(.EXC_VECTOR(32'h00400004), .CNT_W(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exc_sequencer #(.EXC_VECTOR(32'h00400004), .CNT_W(2)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic sys, input logic brk, input logic teq,
                               input logic teq_eq, input logic er,
                               input logic [31:0] status, input logic [31:0] pc);
    bus.is_syscall = sys;
    bus.is_break   = brk;
    bus.is_teq     = teq;
    bus.teq_equal  = teq_eq;
    bus.is_eret    = er;
    bus.status_in  = status;
    bus.npc        = pc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    exp_cnt    = '{1, 2, 3, 3, 3};
    rst        = 1'b1;
    bus.ena    = 1'b1;
    bus.exc_addr_in = 32'hDEADBEEF;
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h0);
    bus2.ena = 1'b1;
    bus2.is_syscall = 1'b0; bus2.is_break = 1'b0; bus2.is_teq = 1'b0;
    bus2.teq_equal = 1'b0;  bus2.is_eret = 1'b0;
    bus2.npc = 32'h0; bus2.status_in = 32'h0; bus2.exc_addr_in = 32'h0;
    tick();
    tick();
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_exception", {31'd0, bus.exception}, 32'd0);
    checkOutput("rst_eret", {31'd0, bus.eret}, 32'd0);
    checkOutput("rst_cause", {27'd0, bus.cause}, 32'd0);
    checkOutput("rst_npc_out", bus.npc_out, 32'd0);
    checkOutput("rst_pc_redirect", {31'd0, bus.pc_redirect}, 32'd0);
    checkOutput("rst_redirect_addr", bus.redirect_addr, 32'd0);
    checkOutput("rst_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("rst_exc_masked", {31'd0, bus.exc_masked}, 32'd0);
    checkOutput("rst_exc_count", {24'd0, bus.exc_count}, 32'd0);

    $display("[TB] taken syscall");
    applyStimulus(1, 0, 0, 0, 0, 32'hF, 32'h00400120);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 32'hF, 32'h0);
    checkOutput("sys_exception", {31'd0, bus.exception}, 32'd1);
    checkOutput("sys_cause", {27'd0, bus.cause}, 32'h08);
    checkOutput("sys_npc_out", bus.npc_out, 32'h00400120);
    checkOutput("sys_stall", {31'd0, bus.stall}, 32'd1);
    checkOutput("sys_no_redirect_yet", {31'd0, bus.pc_redirect}, 32'd0);
    tick();
    checkOutput("sys_exception_drop", {31'd0, bus.exception}, 32'd0);
    checkOutput("sys_pc_redirect", {31'd0, bus.pc_redirect}, 32'd1);
    checkOutput("sys_redirect_addr", bus.redirect_addr, 32'h00400004);
    checkOutput("sys_exc_count", {24'd0, bus.exc_count}, 32'd1);
    tick();
    checkOutput("sys_redirect_drop", {31'd0, bus.pc_redirect}, 32'd0);
    checkOutput("sys_stall_drop", {31'd0, bus.stall}, 32'd0);
    checkOutput("sys_redirect_hold", bus.redirect_addr, 32'h00400004);
    checkOutput("sys_cause_hold", {27'd0, bus.cause}, 32'h08);

    $display("[TB] masked break");
    applyStimulus(0, 1, 0, 0, 0, 32'hB, 32'h00400500);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 32'hF, 32'h0);
    checkOutput("brk_masked_pulse", {31'd0, bus.exc_masked}, 32'd1);
    checkOutput("brk_no_exception", {31'd0, bus.exception}, 32'd0);
    checkOutput("brk_no_stall", {31'd0, bus.stall}, 32'd0);
    checkOutput("brk_cause_hold", {27'd0, bus.cause}, 32'h08);
    tick();
    checkOutput("brk_masked_drop", {31'd0, bus.exc_masked}, 32'd0);
    checkOutput("brk_no_redirect", {31'd0, bus.pc_redirect}, 32'd0);
    checkOutput("brk_count_hold", {24'd0, bus.exc_count}, 32'd1);

    $display("[TB] teq cases");
    applyStimulus(0, 0, 1, 0, 0, 32'hF, 32'h00400600);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 32'hF, 32'h0);
    checkOutput("teq_ne_exception", {31'd0, bus.exception}, 32'd0);
    checkOutput("teq_ne_masked", {31'd0, bus.exc_masked}, 32'd0);
    checkOutput("teq_ne_stall", {31'd0, bus.stall}, 32'd0);
    applyStimulus(0, 0, 1, 1, 0, 32'hF, 32'h00400604);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 32'hF, 32'h0);
    checkOutput("teq_eq_exception", {31'd0, bus.exception}, 32'd1);
    checkOutput("teq_eq_cause", {27'd0, bus.cause}, 32'h0D);
    checkOutput("teq_eq_npc_out", bus.npc_out, 32'h00400604);
    tick();
    tick();
    applyStimulus(1, 0, 1, 1, 0, 32'hF, 32'h00400608);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 32'hF, 32'h0);
    checkOutput("sys_teq_cause", {27'd0, bus.cause}, 32'h08);
    tick();
    tick();
    checkOutput("sys_teq_count", {24'd0, bus.exc_count}, 32'd3);

    $display("[TB] eret");
    applyStimulus(0, 0, 0, 0, 1, 32'hF, 32'h0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 32'hF, 32'h0);
    checkOutput("eret_pulse", {31'd0, bus.eret}, 32'd1);
    checkOutput("eret_no_exception", {31'd0, bus.exception}, 32'd0);
    checkOutput("eret_stall", {31'd0, bus.stall}, 32'd1);
    bus.exc_addr_in = 32'h00400124;
    tick();
    checkOutput("eret_drop", {31'd0, bus.eret}, 32'd0);
    checkOutput("eret_pc_redirect", {31'd0, bus.pc_redirect}, 32'd1);
    checkOutput("eret_redirect_addr", bus.redirect_addr, 32'h00400124);
    checkOutput("eret_count_hold", {24'd0, bus.exc_count}, 32'd3);
    tick();
    applyStimulus(0, 1, 0, 0, 1, 32'hF, 32'h00400700);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 32'hF, 32'h0);
    checkOutput("eret_brk_exception", {31'd0, bus.exception}, 32'd1);
    checkOutput("eret_brk_no_eret", {31'd0, bus.eret}, 32'd0);
    checkOutput("eret_brk_cause", {27'd0, bus.cause}, 32'h09);
    tick();
    checkOutput("eret_brk_redirect_addr", bus.redirect_addr, 32'h00400004);
    tick();

    $display("[TB] reset and enable during sequence");
    applyStimulus(1, 0, 0, 0, 0, 32'hF, 32'h00400200);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 32'hF, 32'h0);
    checkOutput("abort_exception", {31'd0, bus.exception}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_exception_clr", {31'd0, bus.exception}, 32'd0);
    checkOutput("abort_cause_clr", {27'd0, bus.cause}, 32'd0);
    checkOutput("abort_npc_clr", bus.npc_out, 32'd0);
    checkOutput("abort_redirect_clr", bus.redirect_addr, 32'd0);
    checkOutput("abort_count_clr", {24'd0, bus.exc_count}, 32'd0);
    checkOutput("abort_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    checkOutput("abort_no_redirect", {31'd0, bus.pc_redirect}, 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 32'hF, 32'h00400300);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 32'hF, 32'h0);
    checkOutput("ena_exception", {31'd0, bus.exception}, 32'd1);
    bus.ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("ena_hold_exception", {31'd0, bus.exception}, 32'd1);
      checkOutput("ena_hold_no_redirect", {31'd0, bus.pc_redirect}, 32'd0);
      checkOutput("ena_hold_stall", {31'd0, bus.stall}, 32'd1);
    end
    bus.ena = 1'b1;
    tick();
    checkOutput("ena_resume_exception", {31'd0, bus.exception}, 32'd0);
    checkOutput("ena_resume_redirect", {31'd0, bus.pc_redirect}, 32'd1);
    checkOutput("ena_resume_count", {24'd0, bus.exc_count}, 32'd1);
    tick();
    checkOutput("ena_resume_idle", {31'd0, bus.stall}, 32'd0);

    $display("[TB] saturating counter, CNT_W=2");
    bus2.status_in  = 32'hF;
    bus2.npc        = 32'h00400800;
    bus2.is_syscall = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      checkOutput("sat_exception", {31'd0, bus2.exception}, 32'd1);
      checkOutput("sat_stall_exc", {31'd0, bus2.stall}, 32'd1);
      tick();
      checkOutput("sat_redirect", {31'd0, bus2.pc_redirect}, 32'd1);
      checkOutput("sat_stall_redir", {31'd0, bus2.stall}, 32'd1);
      checkOutput("sat_count", {30'd0, bus2.exc_count}, exp_cnt[n]);
      tick();
      checkOutput("sat_idle", {31'd0, bus2.stall}, 32'd0);
    end
    bus2.is_syscall = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
